sprite_compositor: RTL

Parametrised multi-sprite overlay stage that sits between the VGA/QVGA pixel path and the RGB output pins. It generalises the single-ball display and collision path to `NUM_SPRITES` independently positioned sprites. Positions are double-buffered and committed once per frame. Each sprite has a per-frame target-colour collision flag. Pixel, DE and sync signals run through a fixed 2-cycle pipeline.

---
 rtl/sprite_compositor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
// Multi-sprite overlay with per-frame position commit; 2-cycle pixel latency, one pixel per clock, no backpressure.
// Define SPRITE_COLLISION_EN to build the per-sprite target-colour hit accumulator (hit_flags / hit_valid).
module sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPR_SIZE    = 32,
  parameter logic [15:0] KEY_COLOR   = 16'h0000,
  localparam int         IW          = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int         OW          = $clog2(SPR_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   de,
  input  logic                   h_sync_in,
  input  logic                   v_sync_in,
  input  logic [9:0]             x_pixel,
  input  logic [9:0]             y_pixel,
  input  logic [15:0]            camera_pixel,
  input  logic                   is_target_color,
  input  logic                   frame_start,
  input  logic                   spr_wr_en,
  input  logic [IW-1:0]          spr_wr_idx,
  input  logic [9:0]             spr_wr_x,
  input  logic [9:0]             spr_wr_y,
  input  logic                   spr_wr_vis,
  output logic [IW-1:0]          rom_sel,
  output logic [OW-1:0]          rom_x_offset,
  output logic [OW-1:0]          rom_y_offset,
  input  logic [15:0]            rom_pixel,
  output logic [3:0]             red_port,
  output logic [3:0]             green_port,
  output logic [3:0]             blue_port,
  output logic                   de_out,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic [NUM_SPRITES-1:0] hit_flags,
  output logic                   hit_valid
);

  logic [9:0]             sh_x_q  [NUM_SPRITES];
  logic [9:0]             sh_y_q  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_vis_q;
  logic [9:0]             act_x_q [NUM_SPRITES];
  logic [9:0]             act_y_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] act_vis_q;

  // Index compare against each slot means an out-of-range index simply matches nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x_q[i]  <= '0;
        sh_y_q[i]  <= '0;
        act_x_q[i] <= '0;
        act_y_q[i] <= '0;
      end
      sh_vis_q  <= '0;
      act_vis_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (spr_wr_en && (spr_wr_idx == IW'(i))) begin
          sh_x_q[i]   <= spr_wr_x;
          sh_y_q[i]   <= spr_wr_y;
          sh_vis_q[i] <= spr_wr_vis;
        end
        if (frame_start) begin
          if (spr_wr_en && (spr_wr_idx == IW'(i))) begin
            act_x_q[i]   <= spr_wr_x;
            act_y_q[i]   <= spr_wr_y;
            act_vis_q[i] <= spr_wr_vis;
          end else begin
            act_x_q[i]   <= sh_x_q[i];
            act_y_q[i]   <= sh_y_q[i];
            act_vis_q[i] <= sh_vis_q[i];
          end
        end
      end
    end
  end

  logic [NUM_SPRITES-1:0] contain;
  always_comb begin
    contain = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      contain[i] = act_vis_q[i]
        && ({1'b0, x_pixel} >= {1'b0, act_x_q[i]})
        && ({1'b0, x_pixel} <= ({1'b0, act_x_q[i]} + 11'(SPR_SIZE - 1)))
        && ({1'b0, y_pixel} >= {1'b0, act_y_q[i]})
        && ({1'b0, y_pixel} <= ({1'b0, act_y_q[i]} + 11'(SPR_SIZE - 1)));
    end
  end

  logic          win_vld_d;
  logic [IW-1:0] win_idx_d;
  logic [OW-1:0] xoff_d, yoff_d;

  // Scan high to low so the lowest containing index is the last one written.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    xoff_d    = '0;
    yoff_d    = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (contain[i]) begin
        win_vld_d = 1'b1;
        win_idx_d = IW'(i);
        xoff_d    = OW'(x_pixel - act_x_q[i]);
        yoff_d    = OW'(y_pixel - act_y_q[i]);
      end
    end
  end

  logic          win_vld_q;
  logic [IW-1:0] win_idx_q;
  logic [OW-1:0] xoff_q, yoff_q;
  logic [15:0]   cam_q;
  logic          de_q, hs_q, vs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_vld_q <= 1'b0;
      win_idx_q <= '0;
      xoff_q    <= '0;
      yoff_q    <= '0;
      cam_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      win_vld_q <= win_vld_d;
      win_idx_q <= win_idx_d;
      xoff_q    <= xoff_d;
      yoff_q    <= yoff_d;
      cam_q     <= camera_pixel;
      de_q      <= de;
      hs_q      <= h_sync_in;
      vs_q      <= v_sync_in;
    end
  end

  assign rom_sel      = win_idx_q;
  assign rom_x_offset = xoff_q;
  assign rom_y_offset = yoff_q;

  // A transparent winner shows the camera, never a lower-priority sprite.
  logic [15:0] pix_sel;
  logic [11:0] rgb_d, rgb_q;
  logic        de_out_q, hs_out_q, vs_out_q;

  assign pix_sel = (win_vld_q && (rom_pixel != KEY_COLOR)) ? rom_pixel : cam_q;
  assign rgb_d   = de_q ? {pix_sel[15:12], pix_sel[10:7], pix_sel[4:1]} : 12'h000;

  logic unused_pix;
  assign unused_pix = ^{pix_sel[11], pix_sel[6:5], pix_sel[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q    <= '0;
      de_out_q <= 1'b0;
      hs_out_q <= 1'b0;
      vs_out_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      de_out_q <= de_q;
      hs_out_q <= hs_q;
      vs_out_q <= vs_q;
    end
  end

  assign red_port   = rgb_q[11:8];
  assign green_port = rgb_q[7:4];
  assign blue_port  = rgb_q[3:0];
  assign de_out     = de_out_q;
  assign h_sync     = hs_out_q;
  assign v_sync     = vs_out_q;

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] hits_now, hit_acc_q, hit_flags_q;
  logic                   hit_valid_q;

  assign hits_now = (de && is_target_color) ? contain : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_acc_q   <= '0;
      hit_flags_q <= '0;
      hit_valid_q <= 1'b0;
    end else if (frame_start) begin
      hit_flags_q <= hit_acc_q | hits_now;
      hit_acc_q   <= '0;
      hit_valid_q <= 1'b1;
    end else begin
      hit_acc_q   <= hit_acc_q | hits_now;
      hit_valid_q <= 1'b0;
    end
  end

  assign hit_flags = hit_flags_q;
  assign hit_valid = hit_valid_q;
`else
  logic unused_tgt;
  assign unused_tgt = is_target_color;
  assign hit_flags  = '0;
  assign hit_valid  = 1'b0;
`endif

endmodule
